// File: rtl/cordic_vec_seq.sv
// Sequential CORDIC vectoring engine: magnitude and atan2 of a signed 1.4.11 vector.
// Optional CORDIC_VEC_SEQ_GAIN_COMP_EN adds a one-cycle gain-compensation state (x * 0.6073).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a vector, in_ready high, last result held
// FOLD  | move left-half-plane vectors into the right half plane
// ROT   | one micro-rotation per cycle, i = 0 .. ITER-1
// COMP  | scale x by the inverse CORDIC gain (macro builds only)
// DONE  | result presented, held until out_ready
module cordic_vec_seq #(
  parameter int WIDTH = 16,
  parameter int ITER  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mag_out,
  output logic [WIDTH-1:0] angle_out,
  output logic             busy
);

  localparam int W2 = WIDTH + 2;
  localparam logic signed [W2-1:0] PI_C    = W2'(6434);
  localparam logic signed [W2-1:0] SAT_MAX = W2'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [W2-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [3:0]           LAST_I  = 4'(ITER - 1);

  typedef enum logic [2:0] {
    IDLE,
    FOLD,
    ROT,
`ifdef CORDIC_VEC_SEQ_GAIN_COMP_EN
    COMP,
`endif
    DONE
  } state_t;

  state_t                 state_q;
  logic signed [W2-1:0]   x_q, y_q, th_q;
  logic [3:0]             i_q;
  logic                   zero_q;
  logic [WIDTH-1:0]       mag_q, ang_q;

  logic signed [W2-1:0]   x_sh, y_sh, at_i;
  logic signed [W2-1:0]   x_d, y_d, th_d;

  function automatic logic signed [W2-1:0] atan_lut(input logic [3:0] k);
    logic signed [W2-1:0] a;
    case (k)
      4'd0:    a = W2'(1608);
      4'd1:    a = W2'(950);
      4'd2:    a = W2'(502);
      4'd3:    a = W2'(255);
      4'd4:    a = W2'(128);
      4'd5:    a = W2'(64);
      4'd6:    a = W2'(32);
      4'd7:    a = W2'(16);
      4'd8:    a = W2'(8);
      4'd9:    a = W2'(4);
      4'd10:   a = W2'(2);
      4'd11:   a = W2'(1);
      default: a = '0;
    endcase
    return a;
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [W2-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return v[WIDTH-1:0];
  endfunction

  // One micro-rotation from pre-update values; direction driven by the sign of y.
  always_comb begin
    x_sh = x_q >>> i_q;
    y_sh = y_q >>> i_q;
    at_i = atan_lut(i_q);
    x_d  = x_q + y_sh;
    y_d  = y_q - x_sh;
    th_d = th_q + at_i;
    if (y_q[W2-1]) begin
      x_d  = x_q - y_sh;
      y_d  = y_q + x_sh;
      th_d = th_q - at_i;
    end
  end

`ifdef CORDIC_VEC_SEQ_GAIN_COMP_EN
  localparam logic signed [W2+11:0] GAIN_C = (W2+12)'(1244);
  logic signed [W2+11:0] prod;
  logic signed [W2-1:0]  x_cmp;
  assign prod  = x_q * GAIN_C;
  assign x_cmp = prod[W2+10:11];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      th_q    <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= {{2{x_in[WIDTH-1]}}, x_in};
            y_q     <= {{2{y_in[WIDTH-1]}}, y_in};
            th_q    <= '0;
            zero_q  <= (x_in == '0) && (y_in == '0);
            state_q <= FOLD;
          end
        end
        FOLD: begin
          if (x_q[W2-1]) begin
            x_q  <= -x_q;
            y_q  <= -y_q;
            th_q <= y_q[W2-1] ? -PI_C : PI_C;
          end
          i_q     <= '0;
          state_q <= ROT;
        end
        ROT: begin
          x_q  <= x_d;
          y_q  <= y_d;
          th_q <= th_d;
          i_q  <= i_q + 4'd1;
          if (i_q == LAST_I) begin
`ifdef CORDIC_VEC_SEQ_GAIN_COMP_EN
            state_q <= COMP;
`else
            mag_q   <= sat(x_d);
            // A zero vector would otherwise accumulate the whole atan table.
            ang_q   <= zero_q ? '0 : sat(th_d);
            state_q <= DONE;
`endif
          end
        end
`ifdef CORDIC_VEC_SEQ_GAIN_COMP_EN
        COMP: begin
          x_q     <= x_cmp;
          mag_q   <= sat(x_cmp);
          ang_q   <= zero_q ? '0 : sat(th_q);
          state_q <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign mag_out   = mag_q;
  assign angle_out = ang_q;

endmodule

// File: tb/tb_cordic_vec_seq.sv
// Scoreboard bench for cordic_vec_seq: expectations come from real-valued atan2/hypot,
// pushed at each accept and compared by an independent monitor.
module tb_cordic_vec_seq;
  localparam int WIDTH = 16;
  localparam int ITER  = 12;
`ifdef CORDIC_VEC_SEQ_GAIN_COMP_EN
  localparam int  LAT    = ITER + 2;
  localparam real MSCALE = 1244.0 / 2048.0;
`else
  localparam int  LAT    = ITER + 1;
  localparam real MSCALE = 1.0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x_in = '0;
  logic [WIDTH-1:0] y_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] mag_out;
  logic [WIDTH-1:0] angle_out;
  logic             busy;

  cordic_vec_seq #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mag_out(mag_out), .angle_out(angle_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    real ang;
    real mag;
    int  tol_a;
    int  tol_m;
    int  acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_res = 0;
  int   tol_a = 4;
  int   tol_m = 8;
  int   rdy_mode = 1;   // 0 hold low, 1 always ready, 2 random
  real  kgain = 1.0;
  logic prev_valid = 1'b0;

  function automatic real model_ang(input int x, input int y);
    if (x == 0 && y == 0) return 0.0;
    return $atan2(real'(y), real'(x)) * 2048.0;
  endfunction

  function automatic real model_mag(input int x, input int y);
    real rx, ry, m;
    rx = x;
    ry = y;
    m = kgain * MSCALE * $sqrt(rx * rx + ry * ry);
    if (m > 32767.0) m = 32767.0;
    return m;
  endfunction

  task automatic chk_i(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk_r(input string nm, input int act, input real expv, input int tol);
    real d;
    d = real'(act) - expv;
    n_checks++;
    if (d > real'(tol) || d < -real'(tol)) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0.2f +/- %0d (t=%0t)", nm, act, expv, tol, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk_i({tag, "_in_ready"},  int'(in_ready), 1);
    chk_i({tag, "_busy"},      int'(busy), 0);
    chk_i({tag, "_out_valid"}, int'(out_valid), 0);
    chk_i({tag, "_mag"},       int'($signed(mag_out)), 0);
    chk_i({tag, "_angle"},     int'($signed(angle_out)), 0);
  endtask

  // Accept tracker: pushes the model's expectation at every accepting edge.
  always @(posedge clk) begin
    cyc++;
    if (rst && in_valid && in_ready) begin
      exp_q.push_back('{model_ang(int'($signed(x_in)), int'($signed(y_in))),
                        model_mag(int'($signed(x_in)), int'($signed(y_in))),
                        tol_a, tol_m, cyc});
      n_acc++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: checks every presented result against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got out_valid=1, want no pending result (t=%0t)", $time);
        end else begin
          mon_e = exp_q[0];
          if (!prev_valid) chk_i("latency", cyc - mon_e.acc, LAT);
          chk_r("angle", int'($signed(angle_out)), mon_e.ang, mon_e.tol_a);
          chk_r("mag", int'($signed(mag_out)), mon_e.mag, mon_e.tol_m);
          chk_i("in_ready_in_done", int'(in_ready), 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_res++;
          end
        end
      end
      prev_valid = out_valid && !out_ready;
    end
  end

  task automatic send(input int x, input int y, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    x_in = WIDTH'(x);
    y_in = WIDTH'(y);
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want accept", n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!keep) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending, busy=%0d, want 0 pending and idle", exp_q.size(), busy);
    end
  endtask

  int dx[10] = '{2048, 0, 0, -2048, -2048, -1448, 0, 1024, 32767, -32768};
  int dy[10] = '{0, 2048, -2048, 0, -1, -1448, 0, 1024, 32767, 0};
  int da[10] = '{4, 4, 4, 4, 6, 6, 4, 4, 4, 4};
  int dm[10] = '{8, 16, 16, 16, 16, 16, 4, 16, 24, 24};

  initial begin
    int acc0, n, rx, ry;
    logic [15:0] r;
    for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b1;

    for (int k = 0; k < 10; k++) begin
      tol_a = da[k];
      tol_m = dm[k];
      send(dx[k], dy[k], 1'b0);
      wait_idle(100);
    end

    // Back-pressure: result must hold and no second vector may slip in.
    rdy_mode = 0;
    tol_a = 6;
    tol_m = 24;
    send(3000, -500, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_i("hold_result_seen", int'(out_valid), 1);
    x_in = WIDTH'(-700);
    y_in = WIDTH'(2500);
    in_valid = 1'b1;
    acc0 = n_acc;
    repeat (10) begin
      @(negedge clk);
      chk_i("hold_valid", int'(out_valid), 1);
      chk_i("hold_in_ready", int'(in_ready), 0);
    end
    chk_i("hold_no_accept", n_acc, acc0);
    rdy_mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk_i("consume_valid_low", int'(out_valid), 0);
    chk_i("consume_in_ready", int'(in_ready), 1);
    chk_i("consume_busy", int'(busy), 0);
    chk_i("consume_no_accept", n_acc, acc0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_i("second_accept", n_acc, acc0 + 1);
    wait_idle(100);

    // Reset in the middle of rotation, i = 5.
    tol_a = 4;
    tol_m = 16;
    send(5000, 3000, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_reset("mid_rot");
    exp_q.delete();
    @(negedge clk);
    chk_reset("held_rst");
    rst = 1'b1;
    send(1024, 1024, 1'b0);
    wait_idle(100);

    // Streaming with in_valid held high and random back-pressure.
    rdy_mode = 2;
    tol_a = 6;
    tol_m = 24;
    for (int k = 0; k < 1000; k++) begin
      do begin
        r = 16'($urandom);
        rx = int'($signed(r));
        r = 16'($urandom);
        ry = int'($signed(r));
      end while (rx > -4096 && rx < 4096 && ry > -4096 && ry < 4096);
      send(rx, ry, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_mode = 1;
    wait_idle(500);
    chk_i("one_result_per_accept", n_res, n_acc - 1);
    chk_i("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #(900000);
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got time limit at t=%0t, want completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cordic_vec_seq.md
CORDIC_VEC_SEQ -- requirements
Module: cordic_vec_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the sample/angle width in signed 1.4.11 fixed point.
REQ-002 SHALL have parameter ITER, default 12, range 1..12, giving the number of micro-rotations per vector.
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input vector is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-007 SHALL have port x_in, input, WIDTH bits: signed X component.
REQ-008 SHALL have port y_in, input, WIDTH bits: signed Y component.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port mag_out, output, WIDTH bits: signed magnitude in 1.4.11 format.
REQ-012 SHALL have port angle_out, output, WIDTH bits: signed atan2(y,x) in radians, 1.4.11 format.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FOLD, ROT, COMP, DONE; in_ready = 1 only in IDLE.
REQ-015 Accept = in_valid && in_ready at a rising edge; SHALL register x_in and y_in into (WIDTH+2)-bit sign-extended working registers x, y, clear theta, and move IDLE->FOLD.
REQ-016 FOLD (1 cycle): if x<0, SHALL set x=-x, y=-y, theta=+6434 when y>=0 or -6434 when y<0; otherwise SHALL leave them unchanged; SHALL clear counter i; SHALL go to ROT.
REQ-017 ROT: each cycle, if y<0, SHALL set x=x-(y>>>i), y=y+(x>>>i), theta=theta-atan[i]; otherwise x=x+(y>>>i), y=y-(x>>>i), theta=theta+atan[i]; all updates use pre-update values and arithmetic shifts.
REQ-018 atan[0..11] SHALL be the constants 1608, 950, 502, 255, 128, 64, 32, 16, 8, 4, 2, 1.
REQ-019 i SHALL increment each ROT cycle; after the ROT cycle with i=ITER-1, the FSM SHALL go to COMP when the macro is enabled, else to DONE.
REQ-020 Entering DONE, SHALL load mag_out and angle_out from x and theta saturated to the signed WIDTH range; out_valid = 1 in DONE only.
REQ-021 Latency SHALL be: out_valid high ITER+1 cycles after the accept edge without the macro, ITER+2 with it.
REQ-022 DONE SHALL hold mag_out, angle_out and out_valid stable while out_ready=0; when out_ready=1 at an edge, SHALL go to IDLE.
REQ-023 No new vector SHALL be accepted in the cycle a result is consumed; minimum issue interval is ITER+3 (ITER+4 with the macro) cycles.
REQ-024 Input x_in=0, y_in=0 SHALL yield mag_out=0 and angle_out=0 (within +/-4 LSB).
REQ-025 mag_out and angle_out SHALL retain the last result in IDLE.

Reset
REQ-026 rst low, at any time including mid-rotation, SHALL immediately force state=IDLE, i=0, x=y=theta=0, mag_out=0, angle_out=0, out_valid=0, busy=0, in_ready=1; an in-flight vector is discarded.
REQ-027 After rst deasserts, the first accept SHALL occur no earlier than the first rising edge with rst high.

Configuration
REQ-028 Macro CORDIC_VEC_SEQ_GAIN_COMP_EN defined: the COMP state (1 cycle) SHALL set x=(x*1244)>>>11 (gain 0.6073), so mag_out is approximately |v|.
REQ-029 Macro undefined: the COMP state and multiplier SHALL be absent; mag_out SHALL be approximately 1.6468*|v|.

Verification
REQ-030 x=2048, y=0, ITER=12 -> angle_out 0+/-4; mag_out 3373+/-8 without the macro, 2048+/-8 with it.
REQ-031 x=0, y=2048 -> angle_out 3217+/-4; x=0, y=-2048 -> angle_out -3217+/-4.
REQ-032 x=-2048, y=0 -> angle_out 6434+/-4; x=-2048, y=-1 -> angle_out -6434+/-6; x=-1448, y=-1448 -> angle_out -4825+/-6.
REQ-033 Hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; pulse out_ready=1 -> IDLE next cycle; a back-to-back second vector is accepted only after that.
REQ-034 Assert rst during ROT (i=5) -> all outputs read reset values in the same cycle; after release, a fresh vector x=1024, y=1024 -> angle_out 1608+/-4.
REQ-035 in_valid held high continuously with random x/y -> exactly one accept per result; angle_out matches a reference atan2 model within +/-6 LSB over 1000 vectors.
